// File: rtl/fifo_rd_ctrl.sv
// Read-side pointer/flag controller for the async FIFO (r_clk domain), std or FWFT mode.
// Latency: flags/count 1 r_clk after accept or write-pointer change; std data 1 cycle after r_en; FWFT head 2 cycles.
// Backpressure: reads when empty (std) / head invalid (FWFT) are dropped and flagged by a one-cycle underflow pulse.
module fifo_rd_ctrl #(
   parameter int ADDR_WIDTH    = 4,
   parameter int PTR_WIDTH     = ADDR_WIDTH + 1,
   parameter int AEMPTY_THRESH = 2,
   parameter int FWFT          = 0
) (
   input  logic                  r_clk,
   input  logic                  r_rst,
   input  logic                  r_en,
   input  logic [PTR_WIDTH-1:0]  g_wrptr_sync,
   output logic [PTR_WIDTH-1:0]  g_rptr,
   output logic [PTR_WIDTH-1:0]  b_rptr,
   output logic [ADDR_WIDTH-1:0] r_addr,
   output logic                  mem_ren,
   output logic                  rd_valid,
   output logic                  empty,
   output logic                  almost_empty,
   output logic [PTR_WIDTH:0]    rd_count,
   output logic                  underflow
);

   localparam bit               FWFT_ON = (FWFT != 0);
   localparam logic [PTR_WIDTH:0] AE_TH = (PTR_WIDTH+1)'(AEMPTY_THRESH);

   function automatic logic [PTR_WIDTH-1:0] bin2gray(input logic [PTR_WIDTH-1:0] b);
      return b ^ (b >> 1);
   endfunction

   function automatic logic [PTR_WIDTH-1:0] gray2bin(input logic [PTR_WIDTH-1:0] g);
      logic [PTR_WIDTH-1:0] b;
      b[PTR_WIDTH-1] = g[PTR_WIDTH-1];
      for (int i = PTR_WIDTH-2; i >= 0; i--) begin
         b[i] = b[i+1] ^ g[i];
      end
      return b;
   endfunction

   logic [PTR_WIDTH-1:0] b_rptr_q, b_rptr_d;
   logic [PTR_WIDTH-1:0] g_rptr_q, g_rptr_d;
   logic                 ram_empty_q, ram_empty_d;
   logic                 rd_valid_q, rd_valid_d;
   logic                 empty_q, empty_d;
   logic                 almost_empty_q, almost_empty_d;
   logic [PTR_WIDTH:0]   rd_count_q, rd_count_d;
   logic                 underflow_q, underflow_d;
   logic [PTR_WIDTH-1:0] b_wptr;
   logic [PTR_WIDTH-1:0] depth;
   logic                 fetch;

   // State register: reset drops pointers to zero and discards any prefetched head word.
   always_ff @(posedge r_clk or posedge r_rst) begin
      if (r_rst) begin
         b_rptr_q       <= '0;
         g_rptr_q       <= '0;
         ram_empty_q    <= 1'b1;
         rd_valid_q     <= 1'b0;
         empty_q        <= 1'b1;
         almost_empty_q <= 1'b1;
         rd_count_q     <= '0;
         underflow_q    <= 1'b0;
      end else begin
         b_rptr_q       <= b_rptr_d;
         g_rptr_q       <= g_rptr_d;
         ram_empty_q    <= ram_empty_d;
         rd_valid_q     <= rd_valid_d;
         empty_q        <= empty_d;
         almost_empty_q <= almost_empty_d;
         rd_count_q     <= rd_count_d;
         underflow_q    <= underflow_d;
      end
   end

   // Next state: advance pointers on fetch, recompute flags against this cycle's write pointer.
   always_comb begin
      b_wptr   = gray2bin(g_wrptr_sync);
      b_rptr_d = b_rptr_q + {{(PTR_WIDTH-1){1'b0}}, fetch};
      g_rptr_d = bin2gray(b_rptr_d);
      ram_empty_d = (g_rptr_d == g_wrptr_sync);
      if (FWFT_ON) begin
         // Head register: a fetch always (re)fills it; a pop without refill drains it.
         if (fetch)     rd_valid_d = 1'b1;
         else if (r_en) rd_valid_d = 1'b0;
         else           rd_valid_d = rd_valid_q;
         empty_d     = ~rd_valid_d;
         underflow_d = r_en & ~rd_valid_q;
      end else begin
         rd_valid_d  = fetch;
         empty_d     = ram_empty_d;
         underflow_d = r_en & empty_q;
      end
      // Modular subtraction handles wrap; the MSB separates full from empty.
      depth      = b_wptr - b_rptr_d;
      rd_count_d = {1'b0, depth} + {{PTR_WIDTH{1'b0}}, (FWFT_ON & rd_valid_d)};
      almost_empty_d = (rd_count_d <= AE_TH);
   end

   // Outputs: RAM read enable is combinational so the sync RAM sees it in the request cycle.
   always_comb begin
      if (FWFT_ON) fetch = ~ram_empty_q & (~rd_valid_q | r_en);
      else         fetch = r_en & ~empty_q;
      mem_ren      = fetch;
      r_addr       = b_rptr_q[ADDR_WIDTH-1:0];
      b_rptr       = b_rptr_q;
      g_rptr       = g_rptr_q;
      rd_valid     = rd_valid_q;
      empty        = empty_q;
      almost_empty = almost_empty_q;
      rd_count     = rd_count_q;
      underflow    = underflow_q;
   end

endmodule
